hazard_ctrl: RTL
================

# hazard_ctrl

Central pipeline hazard controller for the 5-stage RV32I core. Drives the `bubble*`/`flush*` inputs of every inter-stage segment register (IF/ID, ID/EX, EX/MEM, MEM/WB and the PC register) from three sources:

- load-use data hazards;
- branch/jump redirects, including BTB/BHT mispredicts resolved in EX;
- multi-cycle data-cache misses, tracked by an internal FSM.

It also keeps hazard event counters for the lab's performance analysis.

## Interface

Parameters:
- `CNT_W`, default 32: width of each event counter.

Ports:
- `clk` input 1: core clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `reg1_src_ID` input 5: rs1 of the instruction in ID.
- `reg2_src_ID` input 5: rs2 of the instruction in ID.
- `reg_dest_EX` input 5: rd of the instruction in EX.
- `load_EX` input 1: the EX instruction is a load.
- `jal_ID` input 1: unconditional JAL resolved in ID.
- `redirect_EX` input 1: JALR taken, or branch mispredicted, resolved in EX.
- `dmiss_MEM` input 1: data-cache miss in MEM; held high until serviced.
- `mem_ready` input 1: single-cycle pulse when the miss refill completes.
- `cnt_clr` input 1: synchronous clear of all counters.
- `bubbleF`, `bubbleD`, `bubbleE`, `bubbleM`, `bubbleW` output 1 each: hold the corresponding stage register.
- `flushF`, `flushD`, `flushE`, `flushM`, `flushW` output 1 each: zero the corresponding stage register.
- `stall_cnt` output CNT_W: cycles spent in miss stall.
- `loaduse_cnt` output CNT_W: load-use bubbles inserted.
- `redirect_cnt` output CNT_W: count of `redirect_EX` events.

## Operation

**Miss FSM.** States IDLE and MISS.
- IDLE→MISS when `dmiss_MEM`=1.
- MISS→IDLE on `mem_ready`=1.
- MISS with `dmiss_MEM`=0 and no `mem_ready` stays in MISS; `mem_ready` is the only exit.
- `mem_ready` in IDLE is ignored.

**Stall condition.** `miss_stall` = (state==MISS && !mem_ready) || (state==IDLE && dmiss_MEM).
- While `miss_stall` is active, all five bubble outputs are 1 and all flush outputs are 0.
- All other hazard sources are masked during a miss stall.

**Load-use hazard.** `load_use` = `load_EX` && `reg_dest_EX`!=0 && (`reg_dest_EX`==`reg1_src_ID` || `reg_dest_EX`==`reg2_src_ID`).

**Priority when not stalled** (highest first):
1. `redirect_EX`: `flushD`=1, `flushE`=1. Any coincident `load_use` or `jal_ID` is discarded, because that instruction is squashed.
2. `load_use`: `bubbleF`=1, `bubbleD`=1, `flushE`=1.
3. `jal_ID`: `flushD`=1.
4. Otherwise all outputs are 0.

**Output invariant.** For every stage, bubble and flush are never both 1 in the same cycle. The segment registers ignore flush while bubbled.

**Counters.** Each counter increments by 1 on a clock edge where its condition holds:
- `stall_cnt`: `miss_stall`.
- `loaduse_cnt`: a `load_use` response was actually issued, i.e. after priority resolution.
- `redirect_cnt`: `redirect_EX` && !`miss_stall`.

Counter rules:
- Counters wrap modulo 2^CNT_W.
- `cnt_clr` has priority over increment: the counter becomes 0 that edge.

## Timing

- Bubble/flush outputs are combinational from the current inputs and the FSM state, with zero latency. They act on the segment registers at the same edge.
- FSM state and counters update on the rising edge of `clk`.
- Reset (`rst_n`=0, asynchronous):
  - state=IDLE and all counters=0 immediately;
  - all bubble/flush outputs are forced to 0 while reset is held, regardless of inputs.
- Miss latency: a miss asserted at cycle t with `mem_ready` at cycle t+k gives stall cycles t..t+k-1, so k cycles are added to `stall_cnt`. The pipeline advances at edge t+k.
- If `dmiss_MEM` is asserted in the cycle after `mem_ready` (back-to-back miss), the FSM re-enters MISS with no gap cycle.
- Reset asserted mid-MISS returns the FSM to IDLE. The miss in flight is abandoned.

## Structure

- Shared package `hazard_pkg` holds:
  - the FSM state enum `miss_state_t` (IDLE, MISS);
  - the constant `REG_ZERO`=5'd0.
- Sub-module `event_counter` (parameter W; ports `clk`, `rst_n`, `clr`, `inc`, `cnt`) is instantiated three times.
- All remaining logic is flat in `hazard_ctrl`.

## Test plan

- **Load-use:** `load_EX`=1, `reg_dest_EX`=5, `reg1_src_ID`=5 → `bubbleF`=`bubbleD`=`flushE`=1; `loaduse_cnt` goes 0→1. Same stimulus with `reg_dest_EX`=0 → all outputs 0.
- **Redirect beats load-use:** `redirect_EX`=1 with the load-use stimulus above → only `flushD`=`flushE`=1; `redirect_cnt`=1, `loaduse_cnt` unchanged.
- **Miss stall:** `dmiss_MEM` high for 4 cycles, `mem_ready` pulse in the 4th → all bubbles=1 for 3 cycles; `stall_cnt`=3; FSM back to IDLE. During the stall, `redirect_EX`=1 is masked.
- **Back-to-back miss:** `dmiss_MEM` re-asserted the cycle after `mem_ready` → bubbles resume immediately with no gap cycle.
- **Reset during MISS:** drop `rst_n` for 1 cycle → all outputs 0 during reset, counters 0, FSM IDLE after release.
- **Counter behaviour:** with CNT_W=4, 16 redirects → `redirect_cnt` wraps to 0. `cnt_clr` coincident with an increment → counter reads 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the pipeline hazard controller
package hazard_pkg;
  typedef enum logic {IDLE = 1'b0, MISS = 1'b1} miss_state_t;
  localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: pipeline-facing hazard inputs and segment-register bubble/flush controls
interface hazard_ctrl_if;
  logic [4:0] reg1_src_ID, reg2_src_ID, reg_dest_EX;
  logic load_EX, jal_ID, redirect_EX, dmiss_MEM, mem_ready;
  logic bubbleF, bubbleD, bubbleE, bubbleM, bubbleW;
  logic flushF, flushD, flushE, flushM, flushW;
  modport master (
    output reg1_src_ID, reg2_src_ID, reg_dest_EX, load_EX, jal_ID, redirect_EX, dmiss_MEM, mem_ready,
    input bubbleF, bubbleD, bubbleE, bubbleM, bubbleW, flushF, flushD, flushE, flushM, flushW
  );
  modport slave (
    input reg1_src_ID, reg2_src_ID, reg_dest_EX, load_EX, jal_ID, redirect_EX, dmiss_MEM, mem_ready,
    output bubbleF, bubbleD, bubbleE, bubbleM, bubbleW, flushF, flushD, flushE, flushM, flushW
  );
endinterface

// File: rtl/hazard_ctrl_event_counter.sv
// event_counter: wrapping event counter with synchronous clear taking priority over increment
module event_counter #(parameter int W = 32) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc) cnt <= cnt + 1'b1;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use, redirect and d-cache miss hazard resolution with event counters
module hazard_ctrl
  import hazard_pkg::*;
#(parameter int CNT_W = 32) (
  input  logic             clk,
  input  logic             rst_n,
  hazard_ctrl_if.slave     hz,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] loaduse_cnt,
  output logic [CNT_W-1:0] redirect_cnt
);
  miss_state_t state;
  logic miss_stall, load_use, do_rd, do_lu, do_jal;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= (state == IDLE) ? (hz.dmiss_MEM ? MISS : IDLE) : (hz.mem_ready ? IDLE : MISS);
  // every response is gated by rst_n so the pipeline sees no controls while reset is held
  always_comb begin
    miss_stall = rst_n && ((state == MISS && !hz.mem_ready) || (state == IDLE && hz.dmiss_MEM));
    load_use = hz.load_EX && hz.reg_dest_EX != REG_ZERO &&
               (hz.reg_dest_EX == hz.reg1_src_ID || hz.reg_dest_EX == hz.reg2_src_ID);
    do_rd  = rst_n && !miss_stall && hz.redirect_EX;
    do_lu  = rst_n && !miss_stall && !hz.redirect_EX && load_use;
    do_jal = rst_n && !miss_stall && !hz.redirect_EX && !load_use && hz.jal_ID;
  end
  assign hz.bubbleF = miss_stall | do_lu;
  assign hz.bubbleD = miss_stall | do_lu;
  assign hz.bubbleE = miss_stall;
  assign hz.bubbleM = miss_stall;
  assign hz.bubbleW = miss_stall;
  assign hz.flushF  = 1'b0;
  assign hz.flushD  = do_rd | do_jal;
  assign hz.flushE  = do_rd | do_lu;
  assign hz.flushM  = 1'b0;
  assign hz.flushW  = 1'b0;
  event_counter #(.W(CNT_W)) u_stall    (.clk(clk), .rst_n(rst_n), .clr(cnt_clr), .inc(miss_stall), .cnt(stall_cnt));
  event_counter #(.W(CNT_W)) u_loaduse  (.clk(clk), .rst_n(rst_n), .clr(cnt_clr), .inc(do_lu),      .cnt(loaduse_cnt));
  event_counter #(.W(CNT_W)) u_redirect (.clk(clk), .rst_n(rst_n), .clr(cnt_clr), .inc(do_rd),      .cnt(redirect_cnt));
endmodule
